// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 4-bit instruction register, a 1-bit bypass
// register and one-hot DR selection. All outputs are decoded from registered
// state, so tms never reaches an output combinationally.
// Optional feature macro: USERCODE_INSTR_EN enables the USERCODE opcode 4'b0011.
// When the macro is not defined, that opcode decodes to BYPASS.
module tap_controller (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    input  logic       tdi,
    input  logic       idcode_tdo,
    input  logic       bsr_tdo,
    input  logic       usercode_tdo,
    output logic       clockDR,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateDR,
    output logic       select_idcode,
    output logic       select_bypass,
    output logic       select_bsr,
    output logic       select_usercode,
    output logic [3:0] ir,
    output logic       tdo,
    output logic       tdo_en
);

    localparam logic [3:0] TLR      = 4'h0;
    localparam logic [3:0] RTI      = 4'h1;
    localparam logic [3:0] SEL_DR   = 4'h2;
    localparam logic [3:0] CAP_DR   = 4'h3;
    localparam logic [3:0] SH_DR    = 4'h4;
    localparam logic [3:0] EX1_DR   = 4'h5;
    localparam logic [3:0] PAUSE_DR = 4'h6;
    localparam logic [3:0] EX2_DR   = 4'h7;
    localparam logic [3:0] UPD_DR   = 4'h8;
    localparam logic [3:0] SEL_IR   = 4'h9;
    localparam logic [3:0] CAP_IR   = 4'hA;
    localparam logic [3:0] SH_IR    = 4'hB;
    localparam logic [3:0] EX1_IR   = 4'hC;
    localparam logic [3:0] PAUSE_IR = 4'hD;
    localparam logic [3:0] EX2_IR   = 4'hE;
    localparam logic [3:0] UPD_IR   = 4'hF;

    localparam logic [3:0] IDCODE_OP = 4'b0001;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] ir_shift;
    logic       bypass_reg;

    // Next-state function of the 16-state TAP FSM.
    always_comb begin
        state_next = state;
        case (state)
            TLR:      state_next = tms ? TLR      : RTI;
            RTI:      state_next = tms ? SEL_DR   : RTI;
            SEL_DR:   state_next = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_next = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_next = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_next = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_next = tms ? SEL_DR   : RTI;
            SEL_IR:   state_next = tms ? TLR      : CAP_IR;
            CAP_IR:   state_next = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_next = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_next = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_next = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_next = tms ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

    // State register; trst wins over tms.
    always_ff @(posedge tck) begin
        if (trst) state <= TLR;
        else      state <= state_next;
    end

    // IR shift register: forced to IDCODE on arrival in TLR so it already
    // reads 4'b0001 during the first TLR cycle.
    always_ff @(posedge tck) begin
        if (trst || state_next == TLR) ir_shift <= IDCODE_OP;
        else if (state == CAP_IR)      ir_shift <= IDCODE_OP;
        else if (state == SH_IR)       ir_shift <= {tdi, ir_shift[3:1]};
    end

    // Instruction register: updated on the edge leaving Update-IR.
    always_ff @(posedge tck) begin
        if (trst || state_next == TLR) ir <= IDCODE_OP;
        else if (state == UPD_IR)      ir <= ir_shift;
    end

    // Bypass register: captures 0, then shifts tdi while BYPASS is selected.
    always_ff @(posedge tck) begin
        if (trst)                                   bypass_reg <= 1'b0;
        else if (select_bypass && state == CAP_DR)  bypass_reg <= 1'b0;
        else if (select_bypass && state == SH_DR)   bypass_reg <= tdi;
    end

    // One-hot DR select decoded from the current instruction.
    always_comb begin
        select_idcode   = 1'b0;
        select_bypass   = 1'b0;
        select_bsr      = 1'b0;
        select_usercode = 1'b0;
        case (ir)
            4'b0000, 4'b0010: select_bsr      = 1'b1;
            4'b0001:          select_idcode   = 1'b1;
`ifdef USERCODE_INSTR_EN
            4'b0011:          select_usercode = 1'b1;
`endif
            default:          select_bypass   = 1'b1;
        endcase
    end

`ifndef USERCODE_INSTR_EN
    logic unused_usercode_tdo;
    assign unused_usercode_tdo = usercode_tdo;
`endif

    // Strobes decoded purely from the registered state.
    assign captureDR = (state == CAP_DR);
    assign shiftDR   = (state == SH_DR);
    assign updateDR  = (state == UPD_DR);
    assign clockDR   = captureDR | shiftDR;
    assign tdo_en    = (state == SH_IR) | shiftDR;

    // Serial output mux from registered sources.
    always_comb begin
        tdo = 1'b0;
        if (state == SH_IR) begin
            tdo = ir_shift[0];
        end else if (state == SH_DR) begin
            if (select_idcode)        tdo = idcode_tdo;
            else if (select_bsr)      tdo = bsr_tdo;
`ifdef USERCODE_INSTR_EN
            else if (select_usercode) tdo = usercode_tdo;
`endif
            else                      tdo = bypass_reg;
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: a table of per-edge vectors plus
// hand-written multi-cycle sequences. Honors USERCODE_INSTR_EN if defined.
module tb_tap_controller;

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       idcode_tdo = 1'b1;
    logic       bsr_tdo = 1'b1;
    logic       usercode_tdo = 1'b1;
    logic       clockDR, captureDR, shiftDR, updateDR;
    logic       select_idcode, select_bypass, select_bsr, select_usercode;
    logic [3:0] ir;
    logic       tdo, tdo_en;

    int unsigned errors = 0;
    int unsigned checks = 0;

    tap_controller dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi),
        .idcode_tdo(idcode_tdo), .bsr_tdo(bsr_tdo), .usercode_tdo(usercode_tdo),
        .clockDR(clockDR), .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
        .select_idcode(select_idcode), .select_bypass(select_bypass),
        .select_bsr(select_bsr), .select_usercode(select_usercode),
        .ir(ir), .tdo(tdo), .tdo_en(tdo_en)
    );

    always #5 tck = ~tck;

    // strobes {clockDR,captureDR,shiftDR,updateDR,tdo_en}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_CAP  = 5'b11000;
    localparam logic [4:0] S_SH   = 5'b10101;
    localparam logic [4:0] S_UPD  = 5'b00010;
    localparam logic [4:0] S_SHIR = 5'b00001;
    // selects {idcode,bypass,bsr,usercode}
    localparam logic [3:0] SID  = 4'b1000;
    localparam logic [3:0] SBY  = 4'b0100;
    localparam logic [3:0] SBSR = 4'b0010;
    localparam logic [3:0] SUC  = 4'b0001;

    typedef struct {
        logic        trst;
        logic        tms;
        logic        tdi;
        logic [2:0]  dr;    // {idcode_tdo, bsr_tdo, usercode_tdo}
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] obs();
        return {clockDR, captureDR, shiftDR, updateDR, tdo_en, ir,
                select_idcode, select_bypass, select_bsr, select_usercode, tdo};
    endfunction

    task automatic add(input logic r, input logic m, input logic d, input logic [2:0] dr,
                       input logic [4:0] s, input logic [3:0] i, input logic [3:0] sel,
                       input logic t);
        vec_t v;
        v.trst = r; v.tms = m; v.tdi = d; v.dr = dr;
        v.exp = {s, i, sel, t};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic m, input logic d);
        @(negedge tck);
        trst = r; tms = m; tdi = d;
        @(posedge tck);
        #1;
    endtask

    logic [3:0] bits;
    logic [3:0] tdo_exp;
    logic [3:0] uc_sel;
    logic       uc_tdo;

    initial begin
        // reset, DR path with pause/resume, IR load of BSR opcode 0000, TLR via tms
        add(1,0,0,3'b111, S_NONE,4'b0001,SID,0); // 0 reset
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // TLR
        add(0,0,0,3'b111, S_NONE,4'b0001,SID,0); // RTI
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // SelDR
        add(0,0,0,3'b111, S_CAP ,4'b0001,SID,0); // CapDR
        add(0,0,0,3'b100, S_SH  ,4'b0001,SID,1); // ShDR, idcode_tdo=1
        add(0,0,0,3'b011, S_SH  ,4'b0001,SID,0); // ShDR, idcode_tdo=0
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // Ex1DR
        add(0,0,0,3'b111, S_NONE,4'b0001,SID,0); // PauseDR
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // Ex2DR
        add(0,0,0,3'b100, S_SH  ,4'b0001,SID,1); // ShDR, no captureDR
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // Ex1DR
        add(0,1,0,3'b111, S_UPD ,4'b0001,SID,0); // UpdDR
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // SelDR
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // SelIR
        add(0,0,0,3'b111, S_NONE,4'b0001,SID,0); // CapIR
        add(0,0,0,3'b111, S_SHIR,4'b0001,SID,1); // ShIR, capture 0001
        add(0,0,0,3'b111, S_SHIR,4'b0001,SID,0); // shift -> 0000
        add(0,0,0,3'b111, S_SHIR,4'b0001,SID,0);
        add(0,0,0,3'b111, S_SHIR,4'b0001,SID,0);
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // Ex1IR
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0); // UpdIR, ir holds
        add(0,0,0,3'b111, S_NONE,4'b0000,SBSR,0); // RTI, ir=0000
        add(0,1,0,3'b111, S_NONE,4'b0000,SBSR,0); // SelDR
        add(0,0,0,3'b111, S_CAP ,4'b0000,SBSR,0); // CapDR
        add(0,0,0,3'b010, S_SH  ,4'b0000,SBSR,1); // ShDR, bsr_tdo=1
        add(0,0,0,3'b101, S_SH  ,4'b0000,SBSR,0); // ShDR, bsr_tdo=0
        add(0,1,0,3'b111, S_NONE,4'b0000,SBSR,0); // Ex1DR
        add(0,1,0,3'b111, S_UPD ,4'b0000,SBSR,0); // UpdDR
        add(0,0,0,3'b111, S_NONE,4'b0000,SBSR,0); // RTI
        add(0,1,0,3'b111, S_NONE,4'b0000,SBSR,0); // SelDR
        add(0,1,0,3'b111, S_NONE,4'b0000,SBSR,0); // SelIR
        add(0,1,0,3'b111, S_NONE,4'b0001,SID,0);  // TLR, ir back to IDCODE

        for (int i = 0; i < vecs.size(); i++) begin
            {idcode_tdo, bsr_tdo, usercode_tdo} = vecs[i].dr;
            step(vecs[i].trst, vecs[i].tms, vecs[i].tdi);
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Load BYPASS (1111) from reset, then DR scan through bypass
        idcode_tdo = 1'b1; bsr_tdo = 1'b1; usercode_tdo = 1'b1;
        step(1,0,0);
        step(0,0,0); step(0,1,0); step(0,1,0); step(0,0,0); step(0,0,0);
        check("shir_entry", obs(), {S_SHIR, 4'b0001, SID, 1'b1});
        step(0,0,1); step(0,0,1); step(0,0,1); step(0,1,1);
        step(0,1,0);
        step(0,0,0);
        check("ir_bypass", obs(), {S_NONE, 4'b1111, SBY, 1'b0});
        step(0,1,0); step(0,0,0); step(0,0,0);
        bits = 4'b1101;
        tdo_exp = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bypass_tdo%0d", i), {13'd0, tdo}, {13'd0, tdo_exp[i]});
            step(0, (i == 3), bits[i]);
        end
        step(0,1,0); step(0,0,0);

        // IR capture readout 1,0,0,0 while loading opcode 0011
        step(0,1,0); step(0,1,0); step(0,0,0); step(0,0,0);
        bits = 4'b0011;
        tdo_exp = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ir_read%0d", i), {13'd0, tdo}, {13'd0, tdo_exp[i]});
            step(0, (i == 3), bits[i]);
        end
        step(0,1,0);
        check("ir_hold_updir", {10'd0, ir}, {10'd0, 4'b1111});
        step(0,0,0);
`ifdef USERCODE_INSTR_EN
        uc_sel = SUC; uc_tdo = 1'b1;
`else
        uc_sel = SBY; uc_tdo = 1'b0;
`endif
        check("ir_0011", obs(), {S_NONE, 4'b0011, uc_sel, 1'b0});
        idcode_tdo = 1'b0; bsr_tdo = 1'b0; usercode_tdo = 1'b1;
        step(0,1,0); step(0,0,0); step(0,0,0);
        check("usercode_shdr", obs(), {S_SH, 4'b0011, uc_sel, uc_tdo});
        step(0,1,0); step(0,1,0); step(0,0,0);

        // trst in the middle of an IR shift
        idcode_tdo = 1'b1; bsr_tdo = 1'b1; usercode_tdo = 1'b1;
        step(0,1,0); step(0,1,0); step(0,0,0); step(0,0,0);
        step(0,0,1); step(0,0,1);
        step(1,0,1);
        check("trst_midshift", obs(), {S_NONE, 4'b0001, SID, 1'b0});
        step(0,1,0);
        check("tlr_hold", obs(), {S_NONE, 4'b0001, SID, 1'b0});

        // Random walks followed by five tms=1 must land in TLR
        for (int w = 0; w < 6; w++) begin
            int unsigned n;
            n = $urandom_range(1, 14);
            for (int k = 0; k < int'(n); k++)
                step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 5; k++)
                step(0, 1'b1, 1'b0);
            check($sformatf("walk%0d_tlr", w), obs(), {S_NONE, 4'b0001, SID, 1'b0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 SHALL have ports: tck  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: trst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: tms  in  1  TAP mode select.
REQ-004 SHALL have ports: tdi  in  1  serial data in; fans out to IR and all DRs.
REQ-005 SHALL have ports: idcode_tdo, bsr_tdo, usercode_tdo  in  1 each  serial outputs of the external DRs.
REQ-006 SHALL have ports: clockDR  out  1  DR shift/capture enable; high in Capture-DR or Shift-DR.
REQ-007 SHALL have ports: captureDR, shiftDR, updateDR  out  1 each  high while in the matching state.
REQ-008 SHALL have ports: select_idcode, select_bypass, select_bsr, select_usercode  out  1 each  one-hot DR select decoded from IR.
REQ-009 SHALL have ports: ir  out  4  current (updated) instruction.
REQ-010 SHALL have ports: tdo  out  1  serial out; tdo_en  out  1  high in Shift-IR/Shift-DR.

Function
REQ-011 SHALL implement the 16-state 1149.1 FSM: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
REQ-012 Transitions (tms=0 / tms=1): TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; SelIR->CapIR/TLR; Cap*->Sh*/Ex1*; Sh*->Sh*/Ex1*; Ex1*->Pause*/Upd*; Pause*->Pause*/Ex2*; Ex2*->Sh*/Upd*; Upd*->RTI/SelDR.
REQ-013 Five consecutive tck with tms=1 SHALL reach TLR from any state.
REQ-014 IR shift register (4 bits) SHALL load 4'b0001 in CapIR, shift right (tdi into bit 3) in ShIR, hold otherwise.
REQ-015 ir SHALL load from the IR shift register on the rising edge leaving UpdIR; ir SHALL hold during all other states.
REQ-016 In TLR ir SHALL be 4'b0001 (IDCODE); the IR shift register SHALL be 4'b0001 in TLR.
REQ-017 Decode: 4'b0000 -> bsr; 4'b0010 -> bsr; 4'b0001 -> idcode; 4'b1111 -> bypass; any other code -> bypass; exactly one select high at all times.
REQ-018 Internal 1-bit bypass register SHALL capture 0 in CapDR and load tdi in ShDR when select_bypass.
REQ-019 tdo SHALL be IR shift bit 0 in ShIR; the selected DR's serial out in ShDR; 0 otherwise (combinational mux from registered sources).
REQ-020 Strobes SHALL be decoded from the registered state only (no tms path to outputs) and SHALL be glitch-free relative to tck.
REQ-021 The sequence Ex2DR->ShDR SHALL NOT re-assert captureDR; shift resumes with no data loss.

Reset
REQ-022 On trst=1 at a rising edge: state=TLR, ir=4'b0001, IR shift=4'b0001, bypass=0.
REQ-023 Reset SHALL take priority over tms, including mid-shift; partial IR shift contents SHALL be discarded and ir SHALL NOT update.
REQ-024 Outputs after reset: clockDR, captureDR, shiftDR, updateDR, tdo, tdo_en = 0; select_idcode=1, other selects=0.

Configuration
REQ-025 Macro USERCODE_INSTR_EN defined: opcode 4'b0011 SHALL select usercode (select_usercode=1, tdo from usercode_tdo in ShDR).
REQ-026 Macro undefined: 4'b0011 SHALL decode to bypass; select_usercode SHALL be tied 0; usercode_tdo SHALL be ignored.

Verification
REQ-027 From reset, drive tms=0,1,1,0,0 -> state ShIR; shift tdi=1,1,1,1 with tms=0,0,0,1, then tms=1,0 -> ir=4'b1111, select_bypass=1.
REQ-028 IR scan reading: shift 4 bits out of ShIR after CapIR -> tdo sequence 1,0,0,0.
REQ-029 With BYPASS selected, DR scan of tdi=1,0,1,1 -> tdo=0,1,0,1 (one-cycle delay, leading 0).
REQ-030 Random walk to any state, then 5x tms=1 -> TLR, ir=4'b0001, select_idcode=1.
REQ-031 Load ir=4'b0011 -> select_usercode=1 with USERCODE_INSTR_EN; select_bypass=1 without it.
REQ-032 Assert trst during ShIR after 2 of 4 bits shifted -> next cycle TLR, ir=4'b0001, all strobes 0.
